// File: rtl/proc_pkg.sv
// Shared encodings for the multicycle core: opcodes, branch conditions, FSM states, flag bits.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package proc_pkg;

  // Opcode field [15:13]
  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_BCC  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_AND  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  // Branch condition codes, carried in the rX field of Bcc
  localparam logic [2:0] CC_AL = 3'b000;
  localparam logic [2:0] CC_EQ = 3'b001;
  localparam logic [2:0] CC_NE = 3'b010;
  localparam logic [2:0] CC_CC = 3'b011;
  localparam logic [2:0] CC_CS = 3'b100;
  localparam logic [2:0] CC_PL = 3'b101;
  localparam logic [2:0] CC_MI = 3'b110;
  localparam logic [2:0] CC_NV = 3'b111;

  // Bit positions inside the {N,Z,C} flag vector
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'd0,
    ALU_SUB  = 2'd1,
    ALU_AND  = 2'd2,
    ALU_PASS = 2'd3
  } alu_op_t;

  // Evaluates a branch condition against the current {N,Z,C} flags.
  function automatic logic cond_true(input logic [2:0] cc, input logic [2:0] f);
    logic t;
    t = 1'b0;
    case (cc)
      CC_AL:   t = 1'b1;
      CC_EQ:   t = f[FLAG_Z];
      CC_NE:   t = !f[FLAG_Z];
      CC_CC:   t = !f[FLAG_C];
      CC_CS:   t = f[FLAG_C];
      CC_PL:   t = !f[FLAG_N];
      CC_MI:   t = f[FLAG_N];
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/proc_mem_if.sv
// Unified instruction/data memory port: request held until ack, single outstanding access.
// Latency: set by the memory; ack may arrive in the first request cycle or any later one.
// Backpressure: the memory stalls the core simply by withholding mem_ack.
interface proc_mem_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/proc_alu.sv
// Combinational ALU: add, subtract, and, pass-through of operand b, with N/Z/C flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module proc_alu
  import proc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_t           op,
  output logic [DATA_W-1:0] result,
  output logic              n,
  output logic              z,
  output logic              c
);

  // Result and carry; for SUB the carry is "no borrow", i.e. a >= b unsigned.
  always_comb begin
    result = b;
    c      = 1'b0;
    case (op)
      ALU_ADD: {c, result} = {1'b0, a} + {1'b0, b};
      ALU_SUB: begin
        result = a - b;
        c      = (a >= b);
      end
      ALU_AND: result = a & b;
      default: result = b;
    endcase
  end

  assign n = result[DATA_W-1];
  assign z = (result == '0);

endmodule

// File: rtl/proc_multicycle_core.sv
// Multicycle 16-bit-instruction core with flags, conditional branches and run/halt control.
// Latency: ALU/MV/Bcc 3 cycles, LD/ST 4 cycles with zero-wait memory; +1 per memory wait cycle.
// Backpressure: FETCH and MEM hold mem_req and all request fields until mem_ack arrives.
module proc_multicycle_core
  import proc_pkg::*;
#(
  parameter int          DATA_W   = 16,
  parameter int          ADDR_W   = 8,
  parameter int          NUM_REGS = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        run,
  output logic                        done,
  proc_mem_if.master                  mem,
  input  logic [$clog2(NUM_REGS)-1:0] dbg_sel,
  output logic [DATA_W-1:0]           dbg_data,
  output logic [2:0]                  flags
);

  localparam int             RW     = $clog2(NUM_REGS);
  localparam logic [RW-1:0]  PC_IDX = RW'(NUM_REGS - 1);

  state_t              state;
  state_t              state_nxt;
  // The top index is the PC, kept separately in pc; its array slot is never read.
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [ADDR_W-1:0]   pc;
  logic [15:0]         ir;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          flags_q;
  logic                run_low_seen;

  logic [2:0]          op;
  logic                imm;
  logic [2:0]          cc;
  logic [RW-1:0]       rx;
  logic [RW-1:0]       ry;
  logic [DATA_W-1:0]   imm_ext;
  logic [DATA_W-1:0]   rx_val;
  logic [DATA_W-1:0]   ry_val;

  alu_op_t             alu_op;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_n;
  logic                alu_z;
  logic                alu_c;

  logic                wr_en;
  logic [DATA_W-1:0]   wr_data;
  logic                is_alu_op;
  logic                fetch_done;

  assign op      = ir[15:13];
  assign imm     = ir[12];
  assign cc      = ir[11:9];
  assign rx      = ir[9 +: RW];
  assign ry      = ir[0 +: RW];
  assign imm_ext = {{(DATA_W-9){ir[8]}}, ir[8:0]};

  // Register reads: the PC index returns the zero-extended program counter.
  assign rx_val   = (rx == PC_IDX)      ? DATA_W'(pc) : regs[rx];
  assign ry_val   = (ry == PC_IDX)      ? DATA_W'(pc) : regs[ry];
  assign dbg_data = (dbg_sel == PC_IDX) ? DATA_W'(pc) : regs[dbg_sel];

  assign is_alu_op  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  assign fetch_done = (state == S_FETCH) && mem.mem_ack;

  // Map the opcode onto the ALU function; MV uses pass-through of op2.
  always_comb begin
    alu_op = ALU_PASS;
    case (op)
      OP_ADD:  alu_op = ALU_ADD;
      OP_SUB:  alu_op = ALU_SUB;
      OP_AND:  alu_op = ALU_AND;
      default: alu_op = ALU_PASS;
    endcase
  end

  proc_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (alu_op),
    .result (alu_res),
    .n      (alu_n),
    .z      (alu_z),
    .c      (alu_c)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and register-file write control.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_data   = alu_res;
    case (state)
      S_IDLE:   if (run) state_nxt = S_FETCH;
      S_FETCH:  if (mem.mem_ack) state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        case (op)
          OP_LD, OP_ST: state_nxt = S_MEM;
          OP_HALT:      state_nxt = S_HALT;
          OP_BCC:       state_nxt = S_FETCH;
          default: begin
            // MV, ADD, SUB, AND write rX
            state_nxt = S_FETCH;
            wr_en     = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (mem.mem_ack) begin
          state_nxt = S_FETCH;
          wr_en     = (op == OP_LD);
          wr_data   = mem.mem_rdata;
        end
      end
      // Restart only after run has been seen low at least once while halted.
      S_HALT:   if (run && run_low_seen) state_nxt = S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Datapath: IR/PC on fetch, operand latches on decode, flags, branches and writeback.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      pc           <= ADDR_W'(RESET_PC);
      ir           <= '0;
      a_q          <= '0;
      b_q          <= '0;
      addr_q       <= '0;
      flags_q      <= '0;
      run_low_seen <= 1'b0;
    end else begin
      if (fetch_done) begin
        ir <= mem.mem_rdata[15:0];
        pc <= pc + ADDR_W'(1);
      end
      if (state == S_DECODE) begin
        a_q    <= rx_val;
        b_q    <= imm ? imm_ext : ry_val;
        addr_q <= ry_val[ADDR_W-1:0];
      end
      if ((state == S_EXEC) && (op == OP_BCC) && cond_true(cc, flags_q)) begin
        pc <= pc + imm_ext[ADDR_W-1:0];
      end
      if ((state == S_EXEC) && is_alu_op) begin
        flags_q <= {alu_n, alu_z, alu_c};
      end
      // A write to the PC index is a jump; it never coincides with the fetch increment.
      if (wr_en) begin
        if (rx == PC_IDX) pc <= wr_data[ADDR_W-1:0];
        else              regs[rx] <= wr_data;
      end
      run_low_seen <= (state == S_HALT) && (run_low_seen || !run);
    end
  end

  // Request fields come from state and latched operands, so they hold steady during waits.
  assign mem.mem_req   = (state == S_FETCH) || (state == S_MEM);
  assign mem.mem_we    = (state == S_MEM) && (op == OP_ST);
  assign mem.mem_addr  = (state == S_MEM) ? addr_q : pc;
  assign mem.mem_wdata = a_q;

  assign done  = (state == S_HALT);
  assign flags = flags_q;

endmodule

// File: tb/tb_proc_multicycle_core.sv
// Directed bench for proc_multicycle_core with a wait-state-configurable memory model.
// Latency: n/a.
// Backpressure: memory model delays mem_ack by wait_cfg cycles.
module tb_proc_multicycle_core;
  import proc_pkg::*;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 8;
  localparam int NUM_REGS = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              run;
  logic              done;
  logic [2:0]        dbg_sel;
  logic [DATA_W-1:0] dbg_data;
  logic [2:0]        flags;

  proc_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mif ();

  proc_multicycle_core #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .RESET_PC(0)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .run      (run),
    .done     (done),
    .mem      (mif),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data),
    .flags    (flags)
  );

  always #5 clock = ~clock;

  logic [15:0] mem [256];
  int          wait_cfg  = 0;
  int          wait_cnt  = 0;
  logic        stray_ack = 1'b0;
  int          checks    = 0;
  int          errors    = 0;

  // Memory model: ack after wait_cfg idle request cycles, driven on the falling edge.
  initial begin
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = '0;
    forever begin
      @(negedge clock);
      if (mif.mem_req && !reset) begin
        if (wait_cnt >= wait_cfg) begin
          mif.mem_ack   = 1'b1;
          mif.mem_rdata = mem[mif.mem_addr];
          if (mif.mem_we) mem[mif.mem_addr] = mif.mem_wdata;
          wait_cnt = 0;
        end else begin
          mif.mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        mif.mem_ack = stray_ack;
        wait_cnt    = 0;
      end
    end
  end

  function automatic logic [15:0] enc(input logic [2:0] o, input logic im,
                                      input logic [2:0] x, input logic [8:0] lo);
    return {o, im, x, lo};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input int idx, output logic [31:0] v);
    dbg_sel = 3'(idx);
    #1;
    v = 32'(dbg_data);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
  endtask

  logic [31:0] v;
  int          n;

  initial begin
    reset   = 1'b1;
    run     = 1'b0;
    dbg_sel = '0;
    clear_mem();
    mem[0] = enc(OP_MV,   1'b1, 3'd0, 9'd5);
    mem[1] = enc(OP_ADD,  1'b1, 3'd0, 9'h1FB);
    mem[2] = enc(OP_HALT, 1'b0, 3'd0, 9'd0);
    mem[3] = enc(OP_SUB,  1'b1, 3'd1, 9'd1);
    mem[4] = enc(OP_BCC,  1'b0, CC_MI, 9'h1FE);

    // Reset state
    tick(2);
    reset = 1'b0;
    chk("rst_req",   32'(mif.mem_req), 0);
    chk("rst_we",    32'(mif.mem_we), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_flags", 32'(flags), 0);
    chk("rst_state", 32'(dut.state), 32'(S_IDLE));
    rd(0, v); chk("rst_r0", v, 0);
    rd(7, v); chk("rst_pc", v, 0);

    // Stray ack while idle changes nothing
    stray_ack = 1'b1;
    tick(3);
    chk("stray_req",   32'(mif.mem_req), 0);
    chk("stray_state", 32'(dut.state), 32'(S_IDLE));
    rd(7, v); chk("stray_pc", v, 0);
    stray_ack = 1'b0;
    tick(1);

    // MV R0,#5 ; ADD R0,#-5 ; HALT
    run = 1'b1;
    tick(3);
    rd(0, v); chk("mv_before", v, 0);
    tick(1);
    rd(0, v); chk("mv_after", v, 32'h5);
    tick(5);
    chk("done_early", 32'(done), 0);
    tick(1);
    chk("done_rise", 32'(done), 1);
    rd(0, v); chk("add_r0", v, 0);
    chk("add_flags", 32'(flags), 32'b011);
    rd(7, v); chk("halt_pc", v, 32'h3);
    tick(2);
    chk("halt_hold", 32'(done), 1);

    // Re-run resumes at PC+1; SUB R1,#1 then BMI -2 loops
    run = 1'b0;
    tick(1);
    run = 1'b1;
    tick(1);
    chk("rerun_done", 32'(done), 0);
    chk("rerun_req",  32'(mif.mem_req), 1);
    chk("rerun_addr", 32'(mif.mem_addr), 32'h3);
    run = 1'b0;
    tick(3);
    rd(1, v); chk("sub_r1", v, 32'hFFFF);
    chk("sub_flags", 32'(flags), 32'b100);
    chk("bmi_fetch", 32'(mif.mem_addr), 32'h4);
    run = 1'b1;
    tick(3);
    chk("bmi_taken", 32'(mif.mem_addr), 32'h3);
    chk("bmi_done",  32'(done), 0);
    run = 1'b0;

    // Reset during an unacknowledged fetch
    wait_cfg = 1000;
    tick(2);
    chk("stall_req",   32'(mif.mem_req), 1);
    chk("stall_state", 32'(dut.state), 32'(S_FETCH));
    reset = 1'b1;
    tick(1);
    chk("mid_rst_req",   32'(mif.mem_req), 0);
    chk("mid_rst_state", 32'(dut.state), 32'(S_IDLE));
    rd(7, v); chk("mid_rst_pc", v, 0);
    rd(1, v); chk("mid_rst_r1", v, 0);
    reset    = 1'b0;
    wait_cfg = 3;

    // ST R2,[R3] ; LD R4,[R3] with three wait cycles per access
    clear_mem();
    mem[0]     = enc(OP_MV, 1'b1, 3'd2, 9'h0AB);
    mem[1]     = enc(OP_MV, 1'b1, 3'd3, 9'h040);
    mem[2]     = enc(OP_ST, 1'b0, 3'd2, 9'd3);
    mem[3]     = enc(OP_LD, 1'b0, 3'd4, 9'd3);
    mem[8'h40] = 16'h0000;
    run = 1'b1;
    n = 0;
    while (!(mif.mem_req && mif.mem_we) && n < 200) begin
      tick(1);
      n++;
    end
    chk("st_seen", 32'(n < 200), 1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick(1);
      chk("st_req",   32'(mif.mem_req), 1);
      chk("st_we",    32'(mif.mem_we), 1);
      chk("st_addr",  32'(mif.mem_addr), 32'h40);
      chk("st_wdata", 32'(mif.mem_wdata), 32'h00AB);
    end
    tick(1);
    chk("st_end_we",   32'(mif.mem_we), 0);
    chk("st_end_addr", 32'(mif.mem_addr), 32'h3);
    chk("st_mem",      32'(mem[8'h40]), 32'h00AB);
    n = 0;
    while (!done && n < 200) begin
      tick(1);
      n++;
    end
    chk("ld_halt", 32'(n < 200), 1);
    rd(4, v); chk("ld_r4", v, 32'h00AB);
    rd(2, v); chk("ld_r2", v, 32'h00AB);

    // PC wrap at 0xFF and jump by writing the PC register
    run = 1'b0;
    reset = 1'b1;
    tick(1);
    reset    = 1'b0;
    wait_cfg = 0;
    clear_mem();
    mem[0]     = enc(OP_BCC, 1'b0, CC_EQ, 9'd2);
    mem[1]     = enc(OP_AND, 1'b1, 3'd6, 9'd0);
    mem[2]     = enc(OP_MV,  1'b1, 3'd7, 9'h0FF);
    mem[3]     = enc(OP_MV,  1'b1, 3'd7, 9'h010);
    mem[8'hFF] = enc(OP_MV,  1'b1, 3'd5, 9'd7);
    run = 1'b1;
    tick(4);
    chk("beq_not_taken", 32'(mif.mem_addr), 32'h1);
    tick(3);
    chk("and_next", 32'(mif.mem_addr), 32'h2);
    tick(3);
    chk("jump_ff", 32'(mif.mem_addr), 32'hFF);
    tick(3);
    chk("wrap_addr", 32'(mif.mem_addr), 32'h0);
    chk("wrap_req",  32'(mif.mem_req), 1);
    rd(5, v); chk("wrap_r5", v, 32'h7);
    tick(3);
    chk("beq_taken", 32'(mif.mem_addr), 32'h3);
    tick(3);
    chk("jump_10", 32'(mif.mem_addr), 32'h10);
    tick(3);
    chk("final_done", 32'(done), 1);
    rd(7, v); chk("final_pc", v, 32'h11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
